ssram_pattern_tester: RTL and testbench

Self-checking Avalon-MM master that exercises the SSRAM through the tristate SSRAM controller in the test system. It sits directly upstream of that controller's Avalon-MM slave.
- Write pass: fills a configurable word range with an address-derived pattern.
- Read pass: reads the range back with up to MAX_PEND reads in flight and compares every word.
- Reports pass/fail, error count and the first failing address and data.

---
 rtl/ssram_pattern_tester_if.sv | 23 ++
 rtl/ssram_pattern_tester.sv | 200 ++++++++++++++++++++
 tb/tb_ssram_pattern_tester.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssram_pattern_tester_if.sv
// Avalon-MM master bus between the SSRAM pattern tester and the tristate SSRAM controller slave.
interface ssram_pattern_tester_if #(
    parameter int unsigned ADDR_W = 20
);
    logic [ADDR_W+1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/ssram_pattern_tester.sv
// Self-checking Avalon-MM master: writes an address-derived pattern over a word range, reads it
// back with bounded outstanding reads and reports mismatches.
module ssram_pattern_tester #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned START_WORD = 0,
    parameter int unsigned END_WORD   = 2**20 - 1,
    parameter int unsigned MAX_PEND   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [31:0]            seed,
    ssram_pattern_tester_if.master avm,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            err_count,
    output logic [ADDR_W-1:0]      first_err_addr,
    output logic [31:0]            first_err_data
);

    localparam logic [ADDR_W-1:0] START_W = ADDR_W'(START_WORD);
    localparam logic [ADDR_W-1:0] END_W   = ADDR_W'(END_WORD);
    localparam logic [3:0]        MAX_P   = 4'(MAX_PEND);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [31:0]         seed_q, seed_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [ADDR_W-1:0]   caddr_q, caddr_d;
    logic [3:0]          pend_q, pend_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [ADDR_W+1:0]   address_q, address_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [15:0]         err_q, err_d;
    logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
    logic [31:0]         ferr_data_q, ferr_data_d;

    logic w_acc, r_acc, rv, mismatch;

    // Low bits carry the inverted word index so the pattern never collapses to the seed.
    function automatic logic [31:0] pattern(input logic [31:0] s, input logic [ADDR_W-1:0] w);
        logic [ADDR_W-1:0] nw;
        nw = ~w;
        return s ^ {w, nw[31-ADDR_W:0]};
    endfunction

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        caddr_d     = caddr_q;
        read_d      = read_q;
        write_d     = write_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;

        w_acc    = write_q && !avm.avm_waitrequest;
        r_acc    = read_q && !avm.avm_waitrequest;
        rv       = avm.avm_readdatavalid && (pend_q != 4'd0) &&
                   ((state_q == StRead) || (state_q == StDrain));
        mismatch = rv && (avm.avm_readdata != pattern(seed_q, caddr_q));
        pend_d   = pend_q + {3'b000, r_acc} - {3'b000, rv};

        if (rv) begin
            caddr_d = caddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        if (mismatch) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
                ferr_addr_d = caddr_q;
                ferr_data_d = avm.avm_readdata;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StWrite;
                    seed_d      = seed;
                    waddr_d     = START_W;
                    write_d     = 1'b1;
                    read_d      = 1'b0;
                    address_d   = {START_W, 2'b00};
                    wdata_d     = pattern(seed, START_W);
                    pend_d      = 4'd0;
                    err_d       = 16'd0;
                    ferr_addr_d = '0;
                    ferr_data_d = 32'd0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            StWrite: begin
                if (w_acc) begin
                    if (waddr_q == END_W) begin
                        state_d   = StRead;
                        write_d   = 1'b0;
                        read_d    = 1'b1;
                        raddr_d   = START_W;
                        caddr_d   = START_W;
                        pend_d    = 4'd0;
                        address_d = {START_W, 2'b00};
                    end else begin
                        waddr_d   = waddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        address_d = {waddr_d, 2'b00};
                        wdata_d   = pattern(seed_q, waddr_d);
                    end
                end
            end
            StRead: begin
                raddr_d = raddr_q + {{(ADDR_W-1){1'b0}}, r_acc};
                if (r_acc && (raddr_q == END_W)) begin
                    state_d = StDrain;
                    read_d  = 1'b0;
                end else begin
                    // A stalled read stays asserted; otherwise issue only while below the limit.
                    read_d    = (read_q && avm.avm_waitrequest) || (pend_d < MAX_P);
                    address_d = {raddr_d, 2'b00};
                end
            end
            StDrain: begin
                if (pend_d == 4'd0) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 16'd0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            seed_q      <= 32'd0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            caddr_q     <= '0;
            pend_q      <= 4'd0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            wdata_q     <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 16'd0;
            ferr_addr_q <= '0;
            ferr_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            caddr_q     <= caddr_d;
            pend_q      <= pend_d;
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
        end
    end

    assign avm.avm_address    = address_q;
    assign avm.avm_read       = read_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = 4'b1111;
    assign busy               = busy_q;
    assign done               = done_q;
    assign pass               = pass_q;
    assign err_count          = err_q;
    assign first_err_addr     = ferr_addr_q;
    assign first_err_data     = ferr_data_q;

endmodule

// File: tb/tb_ssram_pattern_tester.sv
// Bench for ssram_pattern_tester: SSRAM slave model with configurable latency, stalls and
// fault injection, plus a scoreboard of expected write/read requests.
module tb_ssram_pattern_tester;
    localparam int unsigned AW   = 20;
    localparam int unsigned MAXP = 4;
    localparam int unsigned NW   = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     seed = 32'd0;
    logic            busy, done, pass;
    logic [15:0]     err_count;
    logic [AW-1:0]   first_err_addr;
    logic [31:0]     first_err_data;

    ssram_pattern_tester_if #(.ADDR_W(AW)) bif ();

    ssram_pattern_tester #(
        .ADDR_W(AW), .START_WORD(0), .END_WORD(NW - 1), .MAX_PEND(MAXP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed), .avm(bif.master),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] s, input int unsigned w);
        logic [AW-1:0] a;
        a = AW'(w);
        return s ^ {a, ~a[31-AW:0]};
    endfunction

    typedef struct {
        int          lat;
        bit          rw;
        logic [31:0] seed;
        int          fw;
        bit          restart;
        logic [15:0] exp_err;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        bit          exp_pass;
    } vec_t;

    typedef struct { int due; logic [31:0] data; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wexp_t;

    ret_t        rq[$];
    wexp_t       exp_wq[$];
    logic [31:0] exp_rq[$];
    logic [31:0] mem [NW];

    int          cyc = 0;
    int          lat = 2;
    bit          rand_wait = 1'b0;
    int          fault_word = 99;
    bit          force_valid = 1'b0;
    bit          acc_r_last = 1'b0, vld_last = 1'b0, stall_last = 1'b0;
    logic [23:0] s_ctl;
    logic [31:0] s_data;
    int          outstanding = 0, max_out = 0, pend_viol = 0;
    int          writes_acc = 0, reads_acc = 0;
    int          first_w_cyc = -1, last_w_cyc = -1, first_r_cyc = -1, last_v_cyc = -1;
    logic [31:0] w3_data = 32'd0;

    // Slave model: decisions taken at the falling edge take effect at the next rising edge.
    always @(negedge clk) begin : slave
        bit          acc_w, acc_r;
        logic [2:0]  idx;
        logic [31:0] d;
        wexp_t       e;
        ret_t        r;
        cyc++;
        if (!reset_n) begin
            rq.delete();
            outstanding           = 0;
            acc_r_last            = 1'b0;
            vld_last              = 1'b0;
            stall_last            = 1'b0;
            bif.avm_waitrequest   = 1'b0;
            bif.avm_readdatavalid = 1'b0;
            bif.avm_readdata      = 32'd0;
        end else begin
            if (acc_r_last) outstanding++;
            if (vld_last) outstanding--;
            if (outstanding > max_out) max_out = outstanding;
            if (bif.avm_read && outstanding >= int'(MAXP)) pend_viol++;
            if (stall_last) begin
                chk("stall_ctl", 32'({bif.avm_read, bif.avm_write, bif.avm_address}), 32'(s_ctl));
                chk("stall_wdata", bif.avm_writedata, s_data);
            end

            bif.avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            acc_w = bif.avm_write && !bif.avm_waitrequest;
            acc_r = bif.avm_read && !bif.avm_waitrequest;
            idx   = bif.avm_address[4:2];
            if (acc_w) begin
                if (exp_wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_extra got addr %h want none", bif.avm_address);
                end else begin
                    e = exp_wq.pop_front();
                    chk("wr_addr", 32'(bif.avm_address), e.addr);
                    chk("wr_data", bif.avm_writedata, e.data);
                end
                mem[idx] = bif.avm_writedata;
                if (idx == 3'd3) w3_data = bif.avm_writedata;
                if (writes_acc == 0) first_w_cyc = cyc;
                last_w_cyc = cyc;
                writes_acc++;
            end
            if (acc_r) begin
                if (exp_rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_extra got addr %h want none", bif.avm_address);
                end else begin
                    chk("rd_addr", 32'(bif.avm_address), exp_rq.pop_front());
                end
                d = mem[idx];
                if (int'(idx) == fault_word) d = d ^ 32'd1;
                rq.push_back('{cyc + lat, d});
                if (reads_acc == 0) first_r_cyc = cyc;
                reads_acc++;
            end
            stall_last = (bif.avm_read || bif.avm_write) && bif.avm_waitrequest;
            s_ctl      = {bif.avm_read, bif.avm_write, bif.avm_address};
            s_data     = bif.avm_writedata;
            acc_r_last = acc_r;

            vld_last = 1'b0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                bif.avm_readdatavalid = 1'b1;
                bif.avm_readdata      = r.data;
                vld_last              = 1'b1;
                last_v_cyc            = cyc;
            end else if (force_valid) begin
                bif.avm_readdatavalid = 1'b1;
                bif.avm_readdata      = 32'hDEADBEEF;
            end else begin
                bif.avm_readdatavalid = 1'b0;
                bif.avm_readdata      = 32'h0;
            end
        end
    end

    task automatic run_start(input vec_t v);
        lat        = v.lat;
        rand_wait  = v.rw;
        fault_word = v.fw;
        exp_wq.delete();
        exp_rq.delete();
        for (int w = 0; w < int'(NW); w++) begin
            exp_wq.push_back('{32'(w * 4), pattern(v.seed, w)});
            exp_rq.push_back(32'(w * 4));
        end
        writes_acc  = 0;
        reads_acc   = 0;
        max_out     = 0;
        pend_viol   = 0;
        w3_data     = 32'd0;
        first_w_cyc = -1;
        last_w_cyc  = -1;
        first_r_cyc = -1;
        last_v_cyc  = -1;
        @(negedge clk); #1;
        seed  = v.seed;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        seed  = $urandom;
        chk("start_write", 32'(bif.avm_write), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        if (v.restart) begin
            repeat (2) begin @(negedge clk); #1; end
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic run_finish(input vec_t v);
        int n;
        int done_cyc;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        done_cyc = cyc;
        chk("done_seen", 32'(done), 32'd1);
        chk("err_count", 32'(err_count), 32'(v.exp_err));
        chk("first_err_addr", 32'(first_err_addr), v.exp_addr);
        chk("first_err_data", first_err_data, v.exp_data);
        chk("pass", 32'(pass), 32'(v.exp_pass));
        chk("busy_end", 32'(busy), 32'd0);
        chk("writes", 32'(writes_acc), NW);
        chk("reads", 32'(reads_acc), NW);
        chk("pend_limit", 32'(pend_viol), 32'd0);
        chk("done_latency", 32'(done_cyc), 32'(last_v_cyc + 1));
        if (v.lat == 6 && !v.rw) chk("pend_max", 32'(max_out), MAXP);
        if (!v.rw) begin
            chk("write_burst", 32'(last_w_cyc - first_w_cyc), NW - 1);
            chk("read_follow", 32'(first_r_cyc), 32'(last_w_cyc + 1));
        end
        if (v.seed == 32'd0 && !v.rw) chk("word3_data", w3_data, 32'h00003FFC);
    endtask

    task automatic check_reset_values();
        chk("rst_read", 32'(bif.avm_read), 32'd0);
        chk("rst_write", 32'(bif.avm_write), 32'd0);
        chk("rst_addr", 32'(bif.avm_address), 32'd0);
        chk("rst_wdata", bif.avm_writedata, 32'd0);
        chk("rst_be", 32'(bif.avm_byteenable), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_ferr_addr", 32'(first_err_addr), 32'd0);
        chk("rst_ferr_data", first_err_data, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        vecs[0] = '{2, 1'b0, 32'h0000_0000, 99, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1};
        vecs[1] = '{2, 1'b0, 32'h0000_0000, 5, 1'b0, 16'd1, 32'd5,
                    pattern(32'h0, 5) ^ 32'd1, 1'b0};
        vecs[2] = '{2, 1'b0, 32'h1234_5678, 99, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1};
        vecs[3] = '{3, 1'b1, 32'hA5A5_A5A5, 99, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1};
        vecs[4] = '{6, 1'b0, 32'h0F0F_0F0F, 99, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1};
        vecs[5] = '{2, 1'b0, 32'h0000_55AA, 99, 1'b1, 16'd0, 32'd0, 32'd0, 1'b1};
        vecs[6] = '{6, 1'b1, 32'hC3C3_0001, 7, 1'b0, 16'd1, 32'd7,
                    pattern(32'hC3C3_0001, 7) ^ 32'd1, 1'b1 ^ 1'b1};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values();
        reset_n = 1'b1;

        // Stray readdatavalid while idle must not count as a mismatch.
        @(negedge clk); #1;
        force_valid = 1'b1;
        @(negedge clk); #1;
        force_valid = 1'b0;
        repeat (3) begin @(negedge clk); #1; end
        chk("idle_valid_err", 32'(err_count), 32'd0);
        chk("idle_valid_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_start(vecs[i]);
            run_finish(vecs[i]);
        end

        // Abort mid-read, then a clean run from scratch.
        run_start(vecs[4]);
        n = 0;
        while (reads_acc < 3 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reads_before_abort", 32'(reads_acc), 32'd3);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        run_start(vecs[0]);
        run_finish(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
